// File: rtl/motion_pkg.sv
// Shared widths, saturation limits and ramp state encoding for the motion PI controller.
package motion_pkg;

    localparam int ERR_W     = 12;
    localparam int SAT_ERR_W = 10;
    localparam int INTEG_W   = 16;
    localparam int PI_W      = 12;
    localparam int CMD_W     = 11;
    localparam int P_W       = 14;
    localparam int SPD_W     = 10;
    localparam int SUM_W     = 13;

    localparam logic signed [SAT_ERR_W-1:0] SAT_ERR_MAX = 10'sh1FF;
    localparam logic signed [SAT_ERR_W-1:0] SAT_ERR_MIN = 10'sh200;
    localparam logic signed [INTEG_W-1:0]   INTEG_MAX   = 16'sh7FFF;
    localparam logic signed [INTEG_W-1:0]   INTEG_MIN   = 16'sh8000;
    localparam logic signed [PI_W-1:0]      PI_MAX      = 12'sh7FF;
    localparam logic signed [PI_W-1:0]      PI_MIN      = 12'sh800;
    localparam logic signed [SUM_W-1:0]     MAG_MAX     = 13'sd1023;
    localparam logic signed [SUM_W-1:0]     MAG_MIN     = -13'sd1023;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

endpackage

// File: rtl/sm_conv.sv
// Clamps a 13-bit signed wheel sum to +/-1023 and converts it to 11-bit sign-magnitude.
module sm_conv
    import motion_pkg::*;
(
    input  logic signed [SUM_W-1:0] v,
    output logic [CMD_W-1:0]        cmd
);

    logic signed [SUM_W-1:0] c;
    logic [CMD_W-2:0]        mag;

    // The symmetric clamp keeps -1024 out, so a negative value never has zero magnitude.
    always_comb begin
        c = v;
        if (v > MAG_MAX)
            c = MAG_MAX;
        else if (v < MAG_MIN)
            c = MAG_MIN;
        mag = c[SUM_W-1] ? (CMD_W-1)'(-c) : c[CMD_W-2:0];
        cmd = {c[SUM_W-1], mag};
    end

endmodule

// File: rtl/motion_pi_ctrl.sv
// Three-stage saturating PI steering loop with a go/stop speed ramp feeding the wheel driver.
// Define ANTI_WINDUP_EN to freeze the integrator while the previous wheel command was clamped.
module motion_pi_ctrl
    import motion_pkg::*;
#(
    parameter int P_COEFF   = 6,
    parameter int I_SHIFT   = 4,
    parameter int RAMP_STEP = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [ERR_W-1:0] err,
    input  logic             err_vld,
    input  logic [SPD_W-1:0] frwrd,
    output logic [CMD_W-1:0] lft,
    output logic [CMD_W-1:0] rht,
    output logic             out_vld
);

    localparam logic signed [P_W-1:0]   P_K    = P_W'(P_COEFF);
    localparam logic [SPD_W-1:0]        STEP   = SPD_W'(RAMP_STEP);
    localparam logic signed [ERR_W-1:0] ERR_HI = ERR_W'(SAT_ERR_MAX);
    localparam logic signed [ERR_W-1:0] ERR_LO = ERR_W'(SAT_ERR_MIN);

    state_e                      state_q, state_d;
    logic [SPD_W-1:0]            eff_spd_q, eff_spd_d;
    logic signed [INTEG_W-1:0]   integ_q, integ_d;
    logic                        s1_vld_q, s1_vld_d, s1_idle_q, s1_idle_d;
    logic signed [P_W-1:0]       s1_p_q, s1_p_d;
    logic signed [INTEG_W-1:0]   s1_integ_q, s1_integ_d;
    logic [SPD_W-1:0]            s1_spd_q, s1_spd_d;
    logic                        s2_vld_q, s2_vld_d, s2_idle_q, s2_idle_d;
    logic signed [PI_W-1:0]      s2_pi_q, s2_pi_d;
    logic [SPD_W-1:0]            s2_spd_q, s2_spd_d;
    logic [CMD_W-1:0]            lft_q, lft_d, rht_q, rht_d;
    logic                        out_vld_q, out_vld_d, zero_pend_q, zero_pend_d;

    logic signed [ERR_W-1:0]     err_s;
    logic signed [SAT_ERR_W-1:0] sat_err;
    logic signed [P_W-1:0]       p_term;
    logic signed [INTEG_W:0]     integ_sum;
    logic signed [INTEG_W-1:0]   integ_upd, integ_next;
    logic [SPD_W-1:0]            target, spd_ramped;
    logic                        acc, go_idle;
    logic signed [INTEG_W-1:0]   i_term;
    logic signed [INTEG_W:0]     pi_sum;
    logic signed [SUM_W-1:0]     ls, rs;
    logic [CMD_W-1:0]            lft_cmd, rht_cmd;

    assign err_s = $signed(err);
    assign acc   = err_vld && (state_q != IDLE || go);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sat_err = err_s[SAT_ERR_W-1:0];
        if (err_s > ERR_HI)
            sat_err = SAT_ERR_MAX;
        else if (err_s < ERR_LO)
            sat_err = SAT_ERR_MIN;

        p_term    = P_W'(sat_err) * P_K;
        integ_sum = (INTEG_W+1)'(integ_q) + (INTEG_W+1)'(sat_err);
        integ_upd = integ_sum[INTEG_W-1:0];
        if (integ_sum > (INTEG_W+1)'(INTEG_MAX))
            integ_upd = INTEG_MAX;
        else if (integ_sum < (INTEG_W+1)'(INTEG_MIN))
            integ_upd = INTEG_MIN;

        // The go level picks the ramp target, so the sample that sees go drop already ramps down.
        target = go ? frwrd : '0;
        if (eff_spd_q < target)
            spd_ramped = (target - eff_spd_q > STEP) ? eff_spd_q + STEP : target;
        else
            spd_ramped = (eff_spd_q - target > STEP) ? eff_spd_q - STEP : target;

        state_d   = state_q;
        eff_spd_d = eff_spd_q;
        integ_d   = integ_q;
        go_idle   = 1'b0;
        if (acc) begin
            eff_spd_d = spd_ramped;
            integ_d   = integ_next;
            case (state_q)
                IDLE: state_d = RUN;
                RUN:  if (!go) state_d = STOP;
                STOP: begin
                    if (go) begin
                        state_d = RUN;
                    end else if (spd_ramped == '0) begin
                        state_d = IDLE;
                        integ_d = '0;
                        go_idle = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        s1_vld_d   = acc;
        s1_idle_d  = go_idle;
        s1_p_d     = p_term;
        s1_integ_d = integ_next;
        s1_spd_d   = spd_ramped;
    end

    always_comb begin
        i_term = s1_integ_q >>> I_SHIFT;
        pi_sum = (INTEG_W+1)'(s1_p_q) + (INTEG_W+1)'(i_term);
        s2_pi_d = pi_sum[PI_W-1:0];
        if (pi_sum > (INTEG_W+1)'(PI_MAX))
            s2_pi_d = PI_MAX;
        else if (pi_sum < (INTEG_W+1)'(PI_MIN))
            s2_pi_d = PI_MIN;
        s2_vld_d  = s1_vld_q;
        s2_idle_d = s1_idle_q;
        s2_spd_d  = s1_spd_q;
    end

    assign ls = $signed({{(SUM_W-SPD_W){1'b0}}, s2_spd_q}) + SUM_W'(s2_pi_q);
    assign rs = $signed({{(SUM_W-SPD_W){1'b0}}, s2_spd_q}) - SUM_W'(s2_pi_q);

    sm_conv u_conv_lft (.v(ls), .cmd(lft_cmd));
    sm_conv u_conv_rht (.v(rs), .cmd(rht_cmd));

    // The last sample before IDLE is still shown for one cycle before the wheels are zeroed.
    always_comb begin
        lft_d = lft_q;
        rht_d = rht_q;
        if (s2_vld_q) begin
            lft_d = lft_cmd;
            rht_d = rht_cmd;
        end else if (zero_pend_q) begin
            lft_d = '0;
            rht_d = '0;
        end
        out_vld_d   = s2_vld_q;
        zero_pend_d = s2_vld_q && s2_idle_q;
    end

`ifdef ANTI_WINDUP_EN
    logic aw_clamp_q, aw_clamp_d, aw_neg_q, aw_neg_d;

    always_comb begin
        aw_clamp_d = aw_clamp_q;
        aw_neg_d   = aw_neg_q;
        if (s2_vld_q) begin
            aw_clamp_d = (ls > MAG_MAX) || (ls < MAG_MIN) || (rs > MAG_MAX) || (rs < MAG_MIN);
            aw_neg_d   = s2_pi_q[PI_W-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_clamp_q <= 1'b0;
            aw_neg_q   <= 1'b0;
        end else begin
            aw_clamp_q <= aw_clamp_d;
            aw_neg_q   <= aw_neg_d;
        end
    end

    assign integ_next = (aw_clamp_q && sat_err != '0 && sat_err[SAT_ERR_W-1] == aw_neg_q)
                        ? integ_q : integ_upd;
`else
    assign integ_next = integ_upd;
`endif

    // NOTE: sequential state uses non-blocking assignments so all stages advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            eff_spd_q   <= '0;
            integ_q     <= '0;
            s1_vld_q    <= 1'b0;
            s1_idle_q   <= 1'b0;
            s1_p_q      <= '0;
            s1_integ_q  <= '0;
            s1_spd_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_idle_q   <= 1'b0;
            s2_pi_q     <= '0;
            s2_spd_q    <= '0;
            lft_q       <= '0;
            rht_q       <= '0;
            out_vld_q   <= 1'b0;
            zero_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            eff_spd_q   <= eff_spd_d;
            integ_q     <= integ_d;
            s1_vld_q    <= s1_vld_d;
            s1_idle_q   <= s1_idle_d;
            s1_p_q      <= s1_p_d;
            s1_integ_q  <= s1_integ_d;
            s1_spd_q    <= s1_spd_d;
            s2_vld_q    <= s2_vld_d;
            s2_idle_q   <= s2_idle_d;
            s2_pi_q     <= s2_pi_d;
            s2_spd_q    <= s2_spd_d;
            lft_q       <= lft_d;
            rht_q       <= rht_d;
            out_vld_q   <= out_vld_d;
            zero_pend_q <= zero_pend_d;
        end
    end

    assign lft     = lft_q;
    assign rht     = rht_q;
    assign out_vld = out_vld_q;

endmodule

// File: tb/tb_motion_pi_ctrl.sv
// Directed bench for motion_pi_ctrl: table of single-sample vectors plus stop, clamp and reset sequences.
module tb_motion_pi_ctrl;
    import motion_pkg::*;

    logic        clk = 1'b0;
    logic        rst, go, err_vld;
    logic [11:0] err;
    logic [9:0]  frwrd;
    logic [10:0] lft, rht;
    logic        out_vld;

    int n_checks = 0;
    int n_errors = 0;
    int vld_cnt  = 0;

    typedef struct {
        logic              go;
        logic signed [11:0] err;
        logic [9:0]        frwrd;
        logic [10:0]       lft;
        logic [10:0]       rht;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    motion_pi_ctrl dut (
        .clk(clk), .rst(rst), .go(go), .err(err), .err_vld(err_vld),
        .frwrd(frwrd), .lft(lft), .rht(rht), .out_vld(out_vld)
    );

    always @(negedge clk) if (out_vld === 1'b1) vld_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; go = 1'b0; err_vld = 1'b0; err = '0; frwrd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic g, input logic [11:0] e, input logic [9:0] f);
        @(negedge clk);
        go = g; err = e; frwrd = f; err_vld = 1'b1;
        @(negedge clk);
        err_vld = 1'b0;
    endtask

    task automatic burst(input int n);
        @(negedge clk);
        err_vld = 1'b1;
        repeat (n) @(negedge clk);
        err_vld = 1'b0;
    endtask

    // Counts cycles from the accepting edge until out_vld, giving up after 10.
    task automatic run_vec(input string name, input logic g, input logic [11:0] e, input logic [9:0] f,
                           input logic [10:0] exp_l, input logic [10:0] exp_r);
        int lat;
        send(g, e, f);
        lat = 1;
        while (out_vld !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd3);
        check({name, " lft"}, {21'b0, lft}, {21'b0, exp_l});
        check({name, " rht"}, {21'b0, rht}, {21'b0, exp_r});
    endtask

    initial begin
        int c0;
        vecs[0]  = '{1'b1, 12'sd0,     10'd256, 11'h040, 11'h040};
        vecs[1]  = '{1'b1, 12'sd0,     10'd256, 11'h080, 11'h080};
        vecs[2]  = '{1'b1, 12'sd0,     10'd256, 11'h0C0, 11'h0C0};
        vecs[3]  = '{1'b1, 12'sd0,     10'd256, 11'h100, 11'h100};
        vecs[4]  = '{1'b1, 12'sd0,     10'd256, 11'h100, 11'h100};
        vecs[5]  = '{1'b1, 12'sd20,    10'd256, 11'h179, 11'h087};
        vecs[6]  = '{1'b1, -12'sd1000, 10'd256, 11'h7FF, 11'h3FF};
        vecs[7]  = '{1'b1, -12'sd20,   10'd256, 11'h068, 11'h198};
        vecs[8]  = '{1'b1, 12'sd2000,  10'd256, 11'h3FF, 11'h7FF};
        vecs[9]  = '{1'b1, 12'sd0,     10'd256, 11'h0FF, 11'h101};
        vecs[10] = '{1'b1, 12'sd0,     10'd100, 11'h0BF, 11'h0C1};
        vecs[11] = '{1'b1, 12'sd0,     10'd100, 11'h07F, 11'h081};
        vecs[12] = '{1'b1, 12'sd0,     10'd100, 11'h063, 11'h065};
        vecs[13] = '{1'b1, 12'h800,    10'd100, 11'h7FF, 11'h3FF};
        vecs[14] = '{1'b1, 12'sd22,    10'd101, 11'h0CA, 11'h000};

        reset_dut();
        #1;
        check("reset lft", {21'b0, lft}, 32'd0);
        check("reset rht", {21'b0, rht}, 32'd0);
        check("reset out_vld", {31'b0, out_vld}, 32'd0);

        for (int i = 0; i < 15; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].go, vecs[i].err, vecs[i].frwrd,
                    vecs[i].lft, vecs[i].rht);

        // Ramp to 128, drop go, and let the final sample carry a nonzero PI into IDLE.
        reset_dut();
        run_vec("stop up1", 1'b1, 12'd0, 10'd128, 11'h040, 11'h040);
        run_vec("stop up2", 1'b1, 12'd0, 10'd128, 11'h080, 11'h080);
        run_vec("stop dn1", 1'b0, 12'd0, 10'd128, 11'h040, 11'h040);
        run_vec("stop dn2", 1'b0, 12'd100, 10'd128, 11'h25E, 11'h65E);
        @(negedge clk);
        check("stop zero lft", {21'b0, lft}, 32'd0);
        check("stop zero rht", {21'b0, rht}, 32'd0);
        check("stop integ", {16'b0, dut.integ_q}, 32'd0);
        check("stop state", {30'b0, dut.state_q}, {30'b0, IDLE});
        #1 c0 = vld_cnt;
        send(1'b0, 12'd5, 10'd128);
        repeat (6) @(negedge clk);
        #1 check("stop dropped strobe", 32'(vld_cnt - c0), 32'd0);

        // Back-to-back strobes drive the integrator into its positive rail.
        reset_dut();
        go = 1'b1; frwrd = 10'd0; err = 12'd511;
        #1 c0 = vld_cnt;
        burst(64);
        repeat (5) @(negedge clk);
        #1;
        check("clamp out count", 32'(vld_cnt - c0), 32'd64);
        check("clamp integ 64", {16'b0, dut.integ_q}, 32'h7FC0);
        check("clamp lft", {21'b0, lft}, 32'h3FF);
        check("clamp rht", {21'b0, rht}, 32'h7FF);
        burst(1);
        repeat (5) @(negedge clk);
        check("clamp integ 65", {16'b0, dut.integ_q}, 32'h7FFF);
        burst(5);
        repeat (5) @(negedge clk);
        check("clamp integ 70", {16'b0, dut.integ_q}, 32'h7FFF);
        check("clamp lft 70", {21'b0, lft}, 32'h3FF);

        // Reset lands one cycle after an accepted strobe; outputs must clear without a clock edge.
        reset_dut();
        run_vec("areset pre", 1'b1, 12'd0, 10'd256, 11'h040, 11'h040);
        send(1'b1, 12'd0, 10'd256);
        #2 rst = 1'b1;
        #1;
        check("areset lft", {21'b0, lft}, 32'd0);
        check("areset rht", {21'b0, rht}, 32'd0);
        check("areset out_vld", {31'b0, out_vld}, 32'd0);
        c0 = vld_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1 check("areset no out_vld", 32'(vld_cnt - c0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
